writeback_buffer: RTL and testbench
===================================

WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 Parameter DATA_W, default 16: register data width.
REQ-002 Parameter ADDR_W, default 3: register address width.
REQ-003 Parameter DEPTH, default 2: write-queue entries; power of two, >= 2.
REQ-004 Parameter ZERO_REG, default 1: when 1, writes to address 0 are discarded.
REQ-005 Ports, in order: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-006 in_valid in 1: writeback request present.
REQ-007 in_ready out 1: request can be accepted this cycle.
REQ-008 RegWrite in 1: request writes a register.
REQ-009 RegStore in 2: source select; 00 StoreMem, 01 ALUResult, 10 IPCP2, 11 reserved.
REQ-010 LoadMode in 2: applied to StoreMem only; 00 full word, 01 low byte sign-extended, 10 low byte zero-extended, 11 full word.
REQ-011 IPCP2, ALUResult, StoreMem in DATA_W each: candidate write data.
REQ-012 rdWB in ADDR_W: destination register.
REQ-013 rf_ready in 1: register file consumes the head entry this cycle.
REQ-014 loadData out DATA_W, loadAddr out ADDR_W, regWriteOut out 1: head entry presented to the register file.
REQ-015 fwd_hit out 1, fwd_data out DATA_W, in fwd_addr in ADDR_W: forwarding lookup.
REQ-016 retire_count out 16: number of writes consumed by the register file.

Function
REQ-017 Handshake: accept occurs at a rising edge when in_valid=1 and in_ready=1; in_ready=1 exactly when the queue holds fewer than DEPTH entries.
REQ-018 Accepted requests with RegWrite=0, RegStore=11, or (ZERO_REG=1 and rdWB=0) are consumed but never enqueued.
REQ-019 Enqueued data is the selected source with LoadMode applied, captured at the accept edge.
REQ-020 Latency: an entry accepted into an empty queue appears on loadData/loadAddr with regWriteOut=1 in the cycle after the accept edge.
REQ-021 regWriteOut=1 exactly when the queue is non-empty; when empty, loadData=0, loadAddr=0, regWriteOut=0.
REQ-022 Pop occurs at a rising edge when regWriteOut=1 and rf_ready=1; head data and address hold stable until then.
REQ-023 Simultaneous push and pop in one edge is legal when not full; occupancy is unchanged and order is preserved (FIFO).
REQ-024 When full, in_ready=0 even if rf_ready=1 in the same cycle; no bypass.
REQ-025 Read/write pointers wrap modulo DEPTH; occupancy counter ranges 0..DEPTH.
REQ-026 fwd_hit=1 when any valid entry matches fwd_addr; fwd_data is the youngest matching entry's data, else 0; combinational from queue state.
REQ-027 retire_count increments by 1 on each pop, wraps 0xFFFF -> 0x0000.

Reset
REQ-028 While reset=1 at a rising edge: queue emptied, pointers and occupancy 0, retire_count 0; outputs read loadData=0, loadAddr=0, regWriteOut=0, in_ready=1, fwd_hit=0 on the following cycle.
REQ-029 reset overrides any concurrent accept or pop; in-flight entries are discarded.

Structure
REQ-030 RegStore and LoadMode encodings shall be constants in the shared processor package.
REQ-031 Queue storage and pointers shall be one sub-module, wb_fifo, parametrised by DATA_W+ADDR_W and DEPTH; selection, extension and forwarding live in writeback_buffer.

Verification
REQ-032 Reset: reset=1, in_valid=1, RegStore=01, ALUResult=AAAA, rdWB=101 for one edge -> loadData=0, loadAddr=0, regWriteOut=0, retire_count=0.
REQ-033 Basic write: reset=0, same inputs, rf_ready=1 -> next cycle loadData=AAAA, loadAddr=101, regWriteOut=1; after next edge retire_count=1.
REQ-034 Source/extension: RegStore=00, LoadMode=01, StoreMem=BB80 -> loadData=FF80; LoadMode=10 -> 0080; RegStore=10, IPCP2=CCCC -> CCCC.
REQ-035 Backpressure: rf_ready=0, three accepts offered (rdWB 1,2,3) -> in_ready=0 after two; raising rf_ready drains 1 then 2, then third accepted.
REQ-036 Suppression/forwarding: rdWB=000 or RegWrite=0 -> nothing enqueued; queue holding r4=1111 then r4=2222, fwd_addr=100 -> fwd_hit=1, fwd_data=2222.

Source files
------------

// File: rtl/writeback_buffer_pkg.sv
// Shared encodings for the writeback path: register source select and load extension mode.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package writeback_buffer_pkg;

  // Source of the data written back to the register file.
  typedef enum logic [1:0] {
    RS_STORE_MEM  = 2'b00,
    RS_ALU_RESULT = 2'b01,
    RS_IPCP2      = 2'b10,
    RS_RESERVED   = 2'b11
  } regStore_e;

  // Extension applied to memory data before it is written back.
  typedef enum logic [1:0] {
    LM_WORD      = 2'b00,
    LM_BYTE_SEXT = 2'b01,
    LM_BYTE_ZEXT = 2'b10,
    LM_WORD_ALT  = 2'b11
  } loadMode_e;

  // A request only reaches the queue if it writes a register from a defined source.
  function automatic logic writesRegister(input logic regWrite, input logic [1:0] regStore);
    return regWrite && (regStore_e'(regStore) != RS_RESERVED);
  endfunction

endpackage

// File: rtl/writeback_buffer_wb_fifo.sv
// Circular queue of {addr,data} entries with all slots exposed for forwarding lookup.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: pushReady drops when DEPTH entries are held; no bypass when full.
module wb_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pushValid,
  input  logic [W-1:0]                     pushData,
  output logic                             pushReady,
  input  logic                             popEn,
  output logic                             headValid,
  output logic [W-1:0]                     headData,
  output logic [DEPTH-1:0][W-1:0]          entries,
  output logic [$clog2(DEPTH)-1:0]         rdPtr,
  output logic [$clog2(DEPTH):0]           count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PTR_W-1:0]        wrPtr;
  logic                    doPush;
  logic                    doPop;

  assign pushReady = (count != CNT_W'(DEPTH));
  assign headValid = (count != '0);
  assign doPush    = pushValid && pushReady;
  assign doPop     = popEn && headValid;
  assign headData  = headValid ? mem[rdPtr] : '0;
  assign entries   = mem;

  // Storage is not cleared on reset; occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (doPush && !reset) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; occupancy spans 0..DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// Writeback queue: selects/extends result data, queues register writes, forwards youngest match.
// Latency: accepted write appears at the head one cycle after the accept edge.
// Backpressure: in_ready low while the queue is full; head holds until rf_ready pops it.
module writeback_buffer
  import writeback_buffer_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int DEPTH    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              RegWrite,
  input  logic [1:0]        RegStore,
  input  logic [1:0]        LoadMode,
  input  logic [DATA_W-1:0] IPCP2,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] StoreMem,
  input  logic [ADDR_W-1:0] rdWB,
  input  logic              rf_ready,
  output logic [DATA_W-1:0] loadData,
  output logic [ADDR_W-1:0] loadAddr,
  output logic              regWriteOut,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic [15:0]       retire_count
);

  localparam int ENTRY_W = DATA_W + ADDR_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  logic [DATA_W-1:0]              extMem;
  logic [DATA_W-1:0]              selData;
  logic                           accept;
  logic                           keep;
  logic                           pushValid;
  logic                           pop;
  logic                           headValid;
  logic [ENTRY_W-1:0]             headData;
  logic [DEPTH-1:0][ENTRY_W-1:0]  entries;
  logic [PTR_W-1:0]               rdPtr;
  logic [CNT_W-1:0]               count;
  logic [PTR_W-1:0]               slot;

  // Byte modes look only at the low byte of the memory word.
  always_comb begin
    extMem = StoreMem;
    case (loadMode_e'(LoadMode))
      LM_BYTE_SEXT: extMem = {{(DATA_W-8){StoreMem[7]}}, StoreMem[7:0]};
      LM_BYTE_ZEXT: extMem = {{(DATA_W-8){1'b0}}, StoreMem[7:0]};
      default:      extMem = StoreMem;
    endcase
  end

  // Pick the writeback source; the reserved code never gets enqueued so its data is irrelevant.
  always_comb begin
    selData = '0;
    case (regStore_e'(RegStore))
      RS_STORE_MEM:  selData = extMem;
      RS_ALU_RESULT: selData = ALUResult;
      RS_IPCP2:      selData = IPCP2;
      default:       selData = '0;
    endcase
  end

  // Dropped requests still complete the handshake so the producer is never stalled by them.
  assign accept    = in_valid && in_ready;
  assign keep      = writesRegister(RegWrite, RegStore) && !((ZERO_REG != 0) && (rdWB == '0));
  assign pushValid = accept && keep;
  assign pop       = regWriteOut && rf_ready;

  wb_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .pushValid (pushValid),
    .pushData  ({rdWB, selData}),
    .pushReady (in_ready),
    .popEn     (pop),
    .headValid (headValid),
    .headData  (headData),
    .entries   (entries),
    .rdPtr     (rdPtr),
    .count     (count)
  );

  assign regWriteOut = headValid;
  assign loadData    = headData[DATA_W-1:0];
  assign loadAddr    = headData[ENTRY_W-1:DATA_W];

  // Walk live entries oldest to youngest so the last match seen is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rdPtr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (entries[slot][ENTRY_W-1:DATA_W] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[slot][DATA_W-1:0];
      end
    end
  end

  // Counts register-file consumptions; wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_count <= '0;
    end else if (pop) begin
      retire_count <= retire_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// Self-checking bench for writeback_buffer: directed table, hand sequences, random vs queue model.
// Latency: outputs sampled 1-2 time units after each rising edge.
// Backpressure: rf_ready and in_valid randomised in the model-checked phase.
module tb_writeback_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        RegWrite;
  logic [1:0]  RegStore;
  logic [1:0]  LoadMode;
  logic [15:0] IPCP2;
  logic [15:0] ALUResult;
  logic [15:0] StoreMem;
  logic [2:0]  rdWB;
  logic        rf_ready;
  logic [15:0] loadData;
  logic [2:0]  loadAddr;
  logic        regWriteOut;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic [2:0]  fwd_addr;
  logic [15:0] retire_count;

  int nCompared   = 0;
  int nMismatched = 0;

  writeback_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .RegWrite     (RegWrite),
    .RegStore     (RegStore),
    .LoadMode     (LoadMode),
    .IPCP2        (IPCP2),
    .ALUResult    (ALUResult),
    .StoreMem     (StoreMem),
    .rdWB         (rdWB),
    .rf_ready     (rf_ready),
    .loadData     (loadData),
    .loadAddr     (loadAddr),
    .regWriteOut  (regWriteOut),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data),
    .fwd_addr     (fwd_addr),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rs;
    logic [1:0]  lm;
    logic [15:0] sm;
    logic [15:0] alu;
    logic [15:0] pc;
    logic [2:0]  rd;
    logic [15:0] expData;
  } vec_t;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
  } ent_t;

  vec_t vecs[7];
  ent_t mq[$];
  logic [15:0] mRetire;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference data selection written from the encoding table, not the RTL structure.
  function automatic logic [15:0] modelData(input logic [1:0] rs, input logic [1:0] lm,
                                            input logic [15:0] sm, input logic [15:0] alu,
                                            input logic [15:0] pc);
    int b;
    if (rs == 2'd1) return alu;
    if (rs == 2'd2) return pc;
    b = int'(sm[7:0]);
    if (lm == 2'd1) return (b >= 128) ? 16'(b - 256) : 16'(b);
    if (lm == 2'd2) return 16'(b);
    return sm;
  endfunction

  initial begin
    vecs[0] = '{rs: 2'b01, lm: 2'b00, sm: 16'h0000, alu: 16'hAAAA, pc: 16'h0000, rd: 3'd5, expData: 16'hAAAA};
    vecs[1] = '{rs: 2'b00, lm: 2'b01, sm: 16'hBB80, alu: 16'h1111, pc: 16'h2222, rd: 3'd1, expData: 16'hFF80};
    vecs[2] = '{rs: 2'b00, lm: 2'b10, sm: 16'hBB80, alu: 16'h1111, pc: 16'h2222, rd: 3'd2, expData: 16'h0080};
    vecs[3] = '{rs: 2'b10, lm: 2'b01, sm: 16'hBB80, alu: 16'h1111, pc: 16'hCCCC, rd: 3'd3, expData: 16'hCCCC};
    vecs[4] = '{rs: 2'b00, lm: 2'b00, sm: 16'h1234, alu: 16'h5555, pc: 16'h6666, rd: 3'd7, expData: 16'h1234};
    vecs[5] = '{rs: 2'b00, lm: 2'b11, sm: 16'h8001, alu: 16'h5555, pc: 16'h6666, rd: 3'd6, expData: 16'h8001};
    vecs[6] = '{rs: 2'b00, lm: 2'b01, sm: 16'h447F, alu: 16'h5555, pc: 16'h6666, rd: 3'd4, expData: 16'h007F};

    reset = 1'b1; in_valid = 1'b1; RegWrite = 1'b1; RegStore = 2'b01; LoadMode = 2'b00;
    IPCP2 = 16'h0; ALUResult = 16'hAAAA; StoreMem = 16'h0; rdWB = 3'd5; rf_ready = 1'b0;
    fwd_addr = 3'd5;

    // Reset with a request offered: nothing captured.
    tick();
    check("reset_loadData", 32'(loadData), 32'h0);
    check("reset_loadAddr", 32'(loadAddr), 32'h0);
    check("reset_regWriteOut", 32'(regWriteOut), 32'h0);
    check("reset_retire", 32'(retire_count), 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'h1);
    check("reset_fwd_hit", 32'(fwd_hit), 32'h0);

    // Basic write, one-cycle latency, then retire.
    reset = 1'b0; rf_ready = 1'b1;
    tick();
    check("basic_loadData", 32'(loadData), 32'hAAAA);
    check("basic_loadAddr", 32'(loadAddr), 32'h5);
    check("basic_regWriteOut", 32'(regWriteOut), 32'h1);
    in_valid = 1'b0;
    tick();
    check("basic_retire", 32'(retire_count), 32'h1);
    check("basic_empty", 32'(regWriteOut), 32'h0);

    // Table of source/extension vectors streamed back-to-back with rf_ready high.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; RegWrite = 1'b1;
      RegStore = vecs[i].rs; LoadMode = vecs[i].lm; StoreMem = vecs[i].sm;
      ALUResult = vecs[i].alu; IPCP2 = vecs[i].pc; rdWB = vecs[i].rd;
      tick();
      check($sformatf("vec%0d_data", i), 32'(loadData), 32'(vecs[i].expData));
      check($sformatf("vec%0d_addr", i), 32'(loadAddr), 32'(vecs[i].rd));
    end
    in_valid = 1'b0;
    tick();
    check("table_drained", 32'(regWriteOut), 32'h0);
    check("table_retire", 32'(retire_count), 32'd8);

    // Backpressure: fill two, third stalls, drain releases it in order.
    rf_ready = 1'b0; in_valid = 1'b1; RegWrite = 1'b1; RegStore = 2'b01;
    ALUResult = 16'h0101; rdWB = 3'd1;
    tick();
    check("bp_ready_after1", 32'(in_ready), 32'h1);
    ALUResult = 16'h0202; rdWB = 3'd2;
    tick();
    check("bp_ready_after2", 32'(in_ready), 32'h0);
    check("bp_head1_data", 32'(loadData), 32'h0101);
    ALUResult = 16'h0303; rdWB = 3'd3;
    tick();
    check("bp_stall_ready", 32'(in_ready), 32'h0);
    check("bp_stall_head", 32'(loadAddr), 32'h1);
    rf_ready = 1'b1;
    tick();
    check("bp_no_bypass_head", 32'(loadAddr), 32'h2);
    check("bp_no_bypass_data", 32'(loadData), 32'h0202);
    check("bp_ready_again", 32'(in_ready), 32'h1);
    tick();
    check("bp_third_addr", 32'(loadAddr), 32'h3);
    check("bp_third_data", 32'(loadData), 32'h0303);
    in_valid = 1'b0;
    tick();
    check("bp_empty", 32'(regWriteOut), 32'h0);
    check("bp_retire", 32'(retire_count), 32'd11);

    // Suppression cases followed by forwarding from two writes to the same register.
    rf_ready = 1'b0; in_valid = 1'b1; RegWrite = 1'b1; RegStore = 2'b01;
    ALUResult = 16'hDEAD; rdWB = 3'd0;
    tick();
    check("sup_r0", 32'(regWriteOut), 32'h0);
    rdWB = 3'd4; RegWrite = 1'b0;
    tick();
    check("sup_nowrite", 32'(regWriteOut), 32'h0);
    RegWrite = 1'b1; RegStore = 2'b11;
    tick();
    check("sup_reserved", 32'(regWriteOut), 32'h0);
    RegStore = 2'b01; ALUResult = 16'h1111;
    tick();
    ALUResult = 16'h2222;
    tick();
    in_valid = 1'b0; fwd_addr = 3'd4;
    #1;
    check("fwd_hit_r4", 32'(fwd_hit), 32'h1);
    check("fwd_youngest", 32'(fwd_data), 32'h2222);
    check("fwd_head_oldest", 32'(loadData), 32'h1111);
    fwd_addr = 3'd3;
    #1;
    check("fwd_miss_hit", 32'(fwd_hit), 32'h0);
    check("fwd_miss_data", 32'(fwd_data), 32'h0);
    fwd_addr = 3'd4; rf_ready = 1'b1;
    tick();
    check("fwd_after_pop_hit", 32'(fwd_hit), 32'h1);
    check("fwd_after_pop_data", 32'(fwd_data), 32'h2222);
    tick();
    check("fwd_empty_hit", 32'(fwd_hit), 32'h0);
    check("fwd_retire", 32'(retire_count), 32'd13);

    // Randomised traffic against a queue model; first cycle resets to resynchronise.
    mq.delete();
    mRetire = 16'h0;
    for (int c = 0; c < 500; c++) begin
      reset     = (c == 0) || ($urandom_range(0, 49) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      RegWrite  = ($urandom_range(0, 3) != 0);
      RegStore  = 2'($urandom_range(0, 3));
      LoadMode  = 2'($urandom_range(0, 3));
      StoreMem  = 16'($urandom);
      ALUResult = 16'($urandom);
      IPCP2     = 16'($urandom);
      rdWB      = 3'($urandom_range(0, 7));
      rf_ready  = ($urandom_range(0, 2) != 0);
      fwd_addr  = 3'($urandom_range(0, 7));
      #1;
      if (c > 0) begin
        logic        expHit;
        logic [15:0] expFwd;
        expHit = 1'b0;
        expFwd = 16'h0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
          if (mq[i].addr == fwd_addr) begin
            expHit = 1'b1;
            expFwd = mq[i].data;
            break;
          end
        end
        check("rnd_regWriteOut", 32'(regWriteOut), 32'(mq.size() != 0));
        check("rnd_loadData", 32'(loadData), (mq.size() != 0) ? 32'(mq[0].data) : 32'h0);
        check("rnd_loadAddr", 32'(loadAddr), (mq.size() != 0) ? 32'(mq[0].addr) : 32'h0);
        check("rnd_in_ready", 32'(in_ready), 32'(mq.size() < 2));
        check("rnd_fwd_hit", 32'(fwd_hit), 32'(expHit));
        check("rnd_fwd_data", 32'(fwd_data), 32'(expFwd));
        check("rnd_retire", 32'(retire_count), 32'(mRetire));
      end
      if (reset) begin
        mq.delete();
        mRetire = 16'h0;
      end else begin
        bit acc;
        acc = in_valid && (mq.size() < 2);
        if (rf_ready && mq.size() != 0) begin
          void'(mq.pop_front());
          mRetire = mRetire + 16'h1;
        end
        if (acc && RegWrite && RegStore != 2'b11 && rdWB != 3'd0) begin
          mq.push_back('{addr: rdWB, data: modelData(RegStore, LoadMode, StoreMem, ALUResult, IPCP2)});
        end
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
